// File: rtl/edge_pkg.sv
// Shared types and constants for the Sobel gradient block.
//   state_t            : frame FSM state encoding
//   THETA_*            : quantized edge directions, radians in Q8.8
//   TAN22_Q8/TAN67_Q8  : tan(22.5 deg) and tan(67.5 deg) scaled by 256
//   MAG_MAX            : saturation ceiling for the gradient magnitude
package edge_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INIT_PIXEL = 3'd1,
        COMPUTE    = 3'd2,
        CLASSIFY   = 3'd3,
        COMPLETE   = 3'd4
    } state_t;

    localparam logic signed [15:0] THETA_0   = 16'sd0;
    localparam logic signed [15:0] THETA_45  = 16'sd201;
    localparam logic signed [15:0] THETA_90  = 16'sd402;
    localparam logic signed [15:0] THETA_135 = 16'sd603;

    localparam int TAN22_Q8 = 106;
    localparam int TAN67_Q8 = 618;
    localparam int MAG_MAX  = 32767;

endpackage

// File: rtl/sobel_gradient_if.sv
// Frame-level bus between a frame source/sink and sobel_gradient.
//   enable   : run the frame FSM (low aborts to IDLE)
//   pixel_in : source frame, signed 16-bit per pixel, held stable while enabled
//   done     : one-cycle pulse when the frame is finished
//   gradient : per-pixel Sobel magnitude
//   theta    : per-pixel quantized direction (Q8.8 radians)
// master drives enable/pixel_in, slave (the block) drives the results.
interface sobel_gradient_if #(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5
);
    logic                                      enable;
    logic signed [HEIGHT-1:0][WIDTH-1:0][15:0] pixel_in;
    logic                                      done;
    logic signed [HEIGHT-1:0][WIDTH-1:0][15:0] gradient;
    logic signed [HEIGHT-1:0][WIDTH-1:0][15:0] theta;

    modport master (
        output enable,
        output pixel_in,
        input  done,
        input  gradient,
        input  theta
    );

    modport slave (
        input  enable,
        input  pixel_in,
        output done,
        output gradient,
        output theta
    );
endinterface

// File: rtl/sobel_kernel_3x3.sv
// Combinational 3x3 Sobel kernel.
//   p00..p22 : nine signed 16-bit taps, p<row><col>, row 0 on top
//   gx       : horizontal gradient (right column minus left column)
//   gy       : vertical gradient (bottom row minus top row)
// Column/row weights are 1,2,1; the 20-bit result cannot overflow
// (worst case 4 * 65535 in magnitude).
module sobel_kernel_3x3
    import edge_pkg::*;
(
    input  logic signed [15:0] p00,
    input  logic signed [15:0] p01,
    input  logic signed [15:0] p02,
    input  logic signed [15:0] p10,
    input  logic signed [15:0] p11,
    input  logic signed [15:0] p12,
    input  logic signed [15:0] p20,
    input  logic signed [15:0] p21,
    input  logic signed [15:0] p22,
    output logic signed [19:0] gx,
    output logic signed [19:0] gy
);

    function automatic logic signed [19:0] ext(input logic signed [15:0] v);
        return {{4{v[15]}}, v};
    endfunction

    // The centre tap carries zero weight in both kernels.
    logic unused_center;
    assign unused_center = ^p11;

    assign gx = (ext(p02) + (ext(p12) <<< 1) + ext(p22))
              - (ext(p00) + (ext(p10) <<< 1) + ext(p20));

    assign gy = (ext(p20) + (ext(p21) <<< 1) + ext(p22))
              - (ext(p00) + (ext(p01) <<< 1) + ext(p02));

endmodule

// File: rtl/sobel_gradient.sv
// Frame-sequential Sobel edge detector.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset, clears state and all outputs
//   bus   : sobel_gradient_if slave (enable, pixel_in in; done, gradient, theta out)
// Walks the frame in raster order. Boundary pixels get gradient/theta 0 in
// two cycles; interior pixels take four (init, compute, classify, complete).
// Entries not yet written in the current frame keep their previous values.
module sobel_gradient
    import edge_pkg::*;
#(
    parameter int WIDTH         = 5,
    parameter int HEIGHT        = 5,
    parameter int FRACTION_BITS = 8
) (
    input logic             clk,
    input logic             rst_n,
    sobel_gradient_if.slave bus
);

    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [COL_W-1:0] col_t;

    localparam row_t ROW_LAST = row_t'(HEIGHT - 1);
    localparam col_t COL_LAST = col_t'(WIDTH - 1);

    state_t state, state_n;
    row_t   row, row_up, row_dn;
    col_t   col, col_lf, col_rt;
    logic   is_edge, last_pixel;
    logic   done_q;

    logic signed [15:0] t00, t01, t02, t10, t11, t12, t20, t21, t22;
    logic signed [19:0] gx_k, gy_k;
    logic signed [19:0] gx_p0, gy_p0;

    logic signed [HEIGHT-1:0][WIDTH-1:0][15:0] grad_q;
    logic signed [HEIGHT-1:0][WIDTH-1:0][15:0] theta_q;

    function automatic logic [19:0] abs20(input logic signed [19:0] v);
        return v[19] ? 20'(-v) : 20'(v);
    endfunction

    // |Gx|+|Gy| clipped to the positive 16-bit range.
    function automatic logic signed [15:0] sat_mag(input logic signed [19:0] gx,
                                                   input logic signed [19:0] gy);
        logic [20:0] sum;
        sum = {1'b0, abs20(gx)} + {1'b0, abs20(gy)};
        if (sum > 21'(MAG_MAX))
            return 16'(MAG_MAX);
        return 16'(sum);
    endfunction

    // Four-way direction bin using tangent thresholds in Q8.8, so no divide.
    function automatic logic signed [15:0] classify_theta(input logic signed [19:0] gx,
                                                          input logic signed [19:0] gy);
        logic [31:0] ax, ay, ay_q;
        ax   = 32'(abs20(gx));
        ay   = 32'(abs20(gy));
        ay_q = ay << FRACTION_BITS;
        if (ay_q <= ax * 32'(TAN22_Q8))
            return THETA_0;
        if (ay_q >= ax * 32'(TAN67_Q8))
            return THETA_90;
        // Zero has a clear sign bit, so it groups with the positives.
        if (gx[19] == gy[19])
            return THETA_45;
        return THETA_135;
    endfunction

    // Neighbour indices are clamped so the window stays in range on the
    // boundary; those pixels never use the kernel result.
    assign row_up = (row == '0)      ? row : row - 1'b1;
    assign row_dn = (row == ROW_LAST) ? row : row + 1'b1;
    assign col_lf = (col == '0)      ? col : col - 1'b1;
    assign col_rt = (col == COL_LAST) ? col : col + 1'b1;

    assign is_edge    = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

    assign t00 = bus.pixel_in[row_up][col_lf];
    assign t01 = bus.pixel_in[row_up][col];
    assign t02 = bus.pixel_in[row_up][col_rt];
    assign t10 = bus.pixel_in[row][col_lf];
    assign t11 = bus.pixel_in[row][col];
    assign t12 = bus.pixel_in[row][col_rt];
    assign t20 = bus.pixel_in[row_dn][col_lf];
    assign t21 = bus.pixel_in[row_dn][col];
    assign t22 = bus.pixel_in[row_dn][col_rt];

    sobel_kernel_3x3 u_kernel (
        .p00 (t00),
        .p01 (t01),
        .p02 (t02),
        .p10 (t10),
        .p11 (t11),
        .p12 (t12),
        .p20 (t20),
        .p21 (t21),
        .p22 (t22),
        .gx  (gx_k),
        .gy  (gy_k)
    );

    always_comb begin
        state_n = IDLE;
        if (bus.enable) begin
            case (state)
                IDLE:       state_n = INIT_PIXEL;
                INIT_PIXEL: state_n = is_edge ? COMPLETE : COMPUTE;
                COMPUTE:    state_n = CLASSIFY;
                CLASSIFY:   state_n = COMPLETE;
                COMPLETE:   state_n = last_pixel ? IDLE : INIT_PIXEL;
                default:    state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            done_q  <= 1'b0;
            grad_q  <= '0;
            theta_q <= '0;
        end else begin
            state <= state_n;
            if (!bus.enable) begin
                done_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        done_q <= 1'b0;
                        row    <= '0;
                        col    <= '0;
                    end
                    INIT_PIXEL: begin
                        if (is_edge) begin
                            grad_q[row][col]  <= '0;
                            theta_q[row][col] <= THETA_0;
                        end
                    end
                    // Stage p0: kernel result captured for classification.
                    COMPUTE: begin
                        gx_p0 <= gx_k;
                        gy_p0 <= gy_k;
                    end
                    CLASSIFY: begin
                        grad_q[row][col]  <= sat_mag(gx_p0, gy_p0);
                        theta_q[row][col] <= classify_theta(gx_p0, gy_p0);
                    end
                    COMPLETE: begin
                        if (col != COL_LAST) begin
                            col <= col + 1'b1;
                        end else if (row != ROW_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.done     = done_q;
    assign bus.gradient = grad_q;
    assign bus.theta    = theta_q;

endmodule

// File: tb/tb_sobel_gradient.sv
// Self-checking bench for sobel_gradient: directed frames, random frames,
// abort by enable and by reset, compared against a per-pixel arithmetic model.
module tb_sobel_gradient;

    localparam int W = 5;
    localparam int H = 5;
    localparam int FRAME_EDGES = 69;

    logic clk;
    logic rst_n;

    int tests;
    int failed;

    int pix   [H][W];
    int exp_g [H][W];
    int exp_t [H][W];
    int prv_g [H][W];
    int prv_t [H][W];

    sobel_gradient_if #(.WIDTH(W), .HEIGHT(H)) ifc ();

    sobel_gradient #(.WIDTH(W), .HEIGHT(H), .FRACTION_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv)
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: direct Sobel sums, magnitude clip and tangent-bin rules.
    function automatic void compute_expected();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
                    exp_g[r][c] = 0;
                    exp_t[r][c] = 0;
                end else begin
                    longint gx, gy, ax, ay, m;
                    gx = (pix[r-1][c+1] + 2*pix[r][c+1] + pix[r+1][c+1])
                       - (pix[r-1][c-1] + 2*pix[r][c-1] + pix[r+1][c-1]);
                    gy = (pix[r+1][c-1] + 2*pix[r+1][c] + pix[r+1][c+1])
                       - (pix[r-1][c-1] + 2*pix[r-1][c] + pix[r-1][c+1]);
                    ax = (gx < 0) ? -gx : gx;
                    ay = (gy < 0) ? -gy : gy;
                    m  = ax + ay;
                    exp_g[r][c] = (m > 32767) ? 32767 : int'(m);
                    if (ay*256 <= ax*106)                exp_t[r][c] = 0;
                    else if (ay*256 >= ax*618)           exp_t[r][c] = 402;
                    else if ((gx >= 0) == (gy >= 0))     exp_t[r][c] = 201;
                    else                                 exp_t[r][c] = 603;
                end
            end
        end
    endfunction

    // Pixels whose write edge (boundary: first cycle, interior: third cycle)
    // lies after last_edge keep the previous frame's results.
    function automatic void merge_partial(input int last_edge);
        int t;
        t = 2;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                bit b;
                int we;
                b  = (r == 0 || r == H-1 || c == 0 || c == W-1);
                we = b ? t : t + 2;
                if (we > last_edge) begin
                    exp_g[r][c] = prv_g[r][c];
                    exp_t[r][c] = prv_t[r][c];
                end
                t += b ? 2 : 4;
            end
        end
    endfunction

    function automatic void clear_expected();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                exp_g[r][c] = 0;
                exp_t[r][c] = 0;
            end
    endfunction

    function automatic void save_expected();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                prv_g[r][c] = exp_g[r][c];
                prv_t[r][c] = exp_t[r][c];
            end
    endfunction

    task automatic fill_random(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                logic [15:0] v;
                v = 16'($urandom);
                pix[r][c] = (mode == 0) ? int'($signed(v)) : int'($urandom_range(0, 40)) - 20;
            end
    endtask

    task automatic load_pixels();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                ifc.pixel_in[r][c] = 16'(pix[r][c]);
    endtask

    task automatic compare_outputs(input string tag);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                chk($sformatf("%s grad[%0d][%0d]", tag, r, c),
                    int'($signed(ifc.gradient[r][c])), exp_g[r][c]);
                chk($sformatf("%s theta[%0d][%0d]", tag, r, c),
                    int'($signed(ifc.theta[r][c])), exp_t[r][c]);
            end
    endtask

    // Runs `frames` back-to-back frames with enable held high and checks that
    // done pulses exactly on edges 69, 138, ... then compares the results.
    task automatic run_frame(input string tag, input int frames);
        int n;
        int q[$];
        load_pixels();
        ifc.enable = 1'b1;
        n = 0;
        while (n < FRAME_EDGES*frames + 1) begin
            @(posedge clk);
            n++;
            #1;
            if (ifc.done === 1'b1) q.push_back(n);
        end
        chk($sformatf("%s done_cycles", tag), q.size(), frames);
        for (int i = 0; i < q.size(); i++)
            chk($sformatf("%s done_edge%0d", tag, i), q[i], FRAME_EDGES*(i+1));
        ifc.enable = 1'b0;
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    // Enables the FSM for `edges` edges and reports whether done ever rose.
    task automatic run_partial(input int edges, output bit saw_done);
        saw_done = 1'b0;
        load_pixels();
        ifc.enable = 1'b1;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            if (ifc.done === 1'b1) saw_done = 1'b1;
        end
    endtask

    initial begin
        bit saw;
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        ifc.enable = 1'b0;
        ifc.pixel_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        clear_expected();
        chk("reset done", int'(ifc.done), 0);
        compare_outputs("reset");
        rst_n = 1'b1;

        // Flat frame, two frames back to back to cover the restart
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 100;
        compute_expected();
        run_frame("flat", 2);

        // Vertical step
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = (c >= 2) ? 100 : 0;
        compute_expected();
        run_frame("vstep", 1);

        // Horizontal step
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = (r >= 2) ? 100 : 0;
        compute_expected();
        run_frame("hstep", 1);

        // Diagonal ramp
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 10*(r+c);
        compute_expected();
        run_frame("ramp", 1);

        // Saturating extremes
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = (c == 0) ? -32768 : 32767;
        compute_expected();
        run_frame("sat", 1);

        // Random frames, full range and small range
        for (int k = 0; k < 4; k++) begin
            fill_random(k % 2);
            compute_expected();
            run_frame($sformatf("rand%0d", k), 1);
        end

        // Abort by enable at edge 30: partial frame over the previous results
        save_expected();
        fill_random(1);
        compute_expected();
        merge_partial(29);
        run_partial(29, saw);
        ifc.enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort no_done", int'(saw), 0);
        chk("abort done_low", int'(ifc.done), 0);
        compare_outputs("abort_hold");
        compute_expected();
        run_frame("abort_rerun", 1);

        // Abort by reset at edge 30, enable kept high
        fill_random(0);
        compute_expected();
        run_partial(29, saw);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_abort no_done", int'(saw), 0);
        chk("rst_abort done_low", int'(ifc.done), 0);
        save_expected();
        clear_expected();
        compare_outputs("rst_abort_clear");
        rst_n = 1'b1;
        compute_expected();
        run_frame("rst_rerun", 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sobel_gradient.md
SOBEL_GRADIENT -- requirements
Module: sobel_gradient

Interface
REQ-001 Parameter WIDTH, default 5, meaning frame width in pixels.
REQ-002 Parameter HEIGHT, default 5, meaning frame height in pixels.
REQ-003 Parameter FRACTION_BITS, default 8, meaning fractional bits of the Q8.8 theta output.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 Port clk, input, 1, meaning the only clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1, meaning synchronous active-low reset.
REQ-007 Port enable, input, 1, meaning high runs the frame FSM; low aborts to IDLE.
REQ-008 Port pixel_in, input, signed 16 x [HEIGHT-1:0][WIDTH-1:0], meaning source frame, held stable while enable is high.
REQ-009 Port done, output, 1, meaning one-cycle pulse on frame completion.
REQ-010 Port gradient, output, signed 16 x [HEIGHT-1:0][WIDTH-1:0], meaning Sobel magnitude per pixel.
REQ-011 Port theta, output, signed 16 x [HEIGHT-1:0][WIDTH-1:0], meaning quantized direction, radians Q8.8.

Function
REQ-012 FSM states SHALL be IDLE, INIT_PIXEL, COMPUTE, CLASSIFY, COMPLETE; any other encoding goes to IDLE.
REQ-013 IDLE: clear done, set row=col=0, go INIT_PIXEL.
REQ-014 INIT_PIXEL: boundary pixel (row 0, row HEIGHT-1, col 0, col WIDTH-1) writes gradient=0, theta=0, go COMPLETE; else go COMPUTE.
REQ-015 COMPUTE: register Gx = (p[r-1][c+1]+2p[r][c+1]+p[r+1][c+1]) - (p[r-1][c-1]+2p[r][c-1]+p[r+1][c-1]), Gy = (bottom row, same weights) - (top row); 20-bit signed, no overflow possible.
REQ-016 CLASSIFY: gradient[r][c] = |Gx|+|Gy| saturated to 32767; go COMPLETE.
REQ-017 CLASSIFY theta with ax=|Gx|, ay=|Gy|: ay*256 <= ax*106 -> 0; else ay*256 >= ax*618 -> 402 (pi/2); else Gx,Gy same sign (zero counts as positive) -> 201 (pi/4); else 603 (3pi/4).
REQ-018 COMPLETE: col<WIDTH-1 -> col+1; else row<HEIGHT-1 -> col=0,row+1; both go INIT_PIXEL; last pixel sets done=1, go IDLE.
REQ-019 Latency: boundary pixel 2 cycles, interior 4; WIDTH=HEIGHT=5 frame: done rises on the 69th enabled edge, high exactly one cycle.
REQ-020 With enable held high after done, the FSM SHALL restart a new frame from IDLE.
REQ-021 enable low on any edge: done<=0, state<=IDLE; gradient/theta hold values; next frame restarts at pixel (0,0).
REQ-022 gradient/theta entries not yet written in the current frame SHALL hold prior values.

Reset
REQ-023 rst_n low at a clock edge SHALL force state IDLE, row=col=0, done=0, all gradient and theta entries 0, with priority over enable.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no done pulse; processing restarts from (0,0) on the first enabled edge after release.

Structure
REQ-025 Package edge_pkg SHALL hold state_t, THETA_0/45/90/135 (0/201/402/603), TAN22_Q8=106, TAN67_Q8=618, MAG_MAX=32767.
REQ-026 One combinational sub-module sobel_kernel_3x3 SHALL compute Gx, Gy from nine 16-bit taps; FSM and classification stay in sobel_gradient.

Verification
REQ-027 Flat frame all 100 -> all gradient 0, theta 0, done pulses on edge 69 for one cycle.
REQ-028 Columns 0-1 = 0, columns 2-4 = 100 -> interior col1, col2 gradient 400 theta 0; col3 gradient 0 theta 0.
REQ-029 Rows 0-1 = 0, rows 2-4 = 100 -> interior rows 1, 2 gradient 400 theta 402; row 3 gradient 0.
REQ-030 p[r][c]=10*(r+c) -> every interior gradient 160, theta 201; boundary 0.
REQ-031 Column 0 = -32768, columns 1-4 = 32767 -> interior col1 gradient saturated 32767, theta 0.
REQ-032 enable low at edge 30 then high, and separately rst_n low at edge 30 -> no done pulse; done at edge 69 counted from re-enable/release; reset case shows all outputs 0 before rewrite.
